hdmi_out_align: RTL

// - Downstream stage of the 5x5 median kernel pipeline; drives the HDMI TX encoder.
// - Delays rx-side control (dv/hs/vs, taken at the kernel centre) by LAT cycles to realign it with the median RGB.
// - Tracks pixel position from the realigned control.
// - Optionally overwrites the BORDER-wide frame edge with MASK_RGB; the kernel is incomplete there.

---
 rtl/hdmi_out_align.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hdmi_out_align.sv
// Output stage of the 5x5 median pipeline: realigns kernel-centre control with the median RGB.
// Border masking of the frame edge is built only when HDMI_BORDER_MASK_EN is defined.
module hdmi_out_align #(
  parameter int DATA_W = 8,
  parameter int LAT = 16,
  parameter int BORDER = 2,
  parameter int POS_W = 12,
  parameter logic [3*DATA_W-1:0] MASK_RGB = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_red,
  input  logic [DATA_W-1:0] in_green,
  input  logic [DATA_W-1:0] in_blue,
  input  logic              in_dv,
  input  logic              in_hs,
  input  logic              in_vs,
  output logic              tx_dv,
  output logic              tx_hs,
  output logic              tx_vs,
  output logic [DATA_W-1:0] tx_red,
  output logic [DATA_W-1:0] tx_green,
  output logic [DATA_W-1:0] tx_blue
);

  localparam int RGB_W = 3 * DATA_W;

  if (LAT < 1 || BORDER < 0 || POS_W < 2) begin : g_param_check
    $error("hdmi_out_align: LAT must be >= 1, BORDER >= 0, POS_W >= 2");
  end

  logic [2:0]       dly [LAT];
  logic             d_dv;
  logic             d_vs;
  logic             d_hs;
  logic [RGB_W-1:0] in_rgb;
  logic [RGB_W-1:0] pix_rgb;

  assign in_rgb = {in_red, in_green, in_blue};

  // Control is delayed by the median latency so it lines up with in_rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {in_dv, in_vs, in_hs};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign d_dv = dly[LAT-1][2];
  assign d_vs = dly[LAT-1][1];
  assign d_hs = dly[LAT-1][0];

`ifdef HDMI_BORDER_MASK_EN
  localparam logic [POS_W-1:0] POS_MAX  = '1;
  localparam logic [POS_W:0]   BORDER_X = (POS_W+1)'(BORDER);

  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] width;
  logic [POS_W-1:0] height;
  logic             dv_q;
  logic             vs_q;
  logic             dv_fall;
  logic             vs_rise;
  logic [POS_W:0]   w_lim;
  logic [POS_W:0]   h_lim;
  logic             mask_l;
  logic             mask_t;
  logic             mask_r;
  logic             mask_b;
  logic             mask;

  assign dv_fall = dv_q & ~d_dv;
  assign vs_rise = d_vs & ~vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      width  <= '0;
      height <= '0;
      dv_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      dv_q <= d_dv;
      vs_q <= d_vs;
      if (d_dv) begin
        if (col != POS_MAX) col <= col + POS_W'(1);
      end else if (dv_fall) begin
        col <= '0;
      end
      if (dv_fall) width <= col;
      // A frame start coincident with a line end resets the row rather than advancing it.
      if (vs_rise) begin
        height <= row;
        row    <= '0;
      end else if (dv_fall && row != POS_MAX) begin
        row <= row + POS_W'(1);
      end
    end
  end

  // Limits are one bit wider so a size at or below BORDER masks the whole axis.
  assign w_lim  = {1'b0, width} - BORDER_X;
  assign h_lim  = {1'b0, height} - BORDER_X;
  assign mask_l = {1'b0, col} < BORDER_X;
  assign mask_t = {1'b0, row} < BORDER_X;
  assign mask_r = (width != '0) && (({1'b0, width} <= BORDER_X) || ({1'b0, col} >= w_lim));
  assign mask_b = (height != '0) && (({1'b0, height} <= BORDER_X) || ({1'b0, row} >= h_lim));
  assign mask   = mask_l | mask_t | mask_r | mask_b;

  assign pix_rgb = mask ? MASK_RGB : in_rgb;
`else
  assign pix_rgb = in_rgb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dv    <= 1'b0;
      tx_hs    <= 1'b0;
      tx_vs    <= 1'b0;
      tx_red   <= '0;
      tx_green <= '0;
      tx_blue  <= '0;
    end else begin
      tx_dv <= d_dv;
      tx_hs <= d_hs;
      tx_vs <= d_vs;
      {tx_red, tx_green, tx_blue} <= d_dv ? pix_rgb : '0;
    end
  end

endmodule
